fir_engine: RTL and testbench
=============================

Name: fir_engine

Overview:
- Parametrised successor to the fixed 8-tap, 8-bit FIR top.
- Contains an APB register file, a TAPS-deep signed FIR datapath with a two-stage pipeline, scaling with optional rounding, saturation to DW bits, output decimation, and saturating good/bad result counters.
- Sits between the APB configuration bus and the sample stream.

Parameters:
- DW, 8, sample and result width (signed two's complement)
- CW, 8, coefficient width (signed)
- TAPS, 8, number of taps; legal range 2..32
- SHW, 4, scalefactor width; right shift range is 0..2^SHW-1
- CNTW, 32, goods/bads counter width (at most 32)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- psel  in  1  APB select
- paddr  in  8  APB byte address; bits [1:0] are ignored
- penable  in  1  APB enable
- pwrite  in  1  APB write
- pwdata  in  32  APB write data
- pready  out  1  APB ready; tied to 1 (zero wait states)
- prdata  out  32  APB read data
- sample  in  DW  input sample
- vldin  in  1  sample valid
- result  out  DW  filtered, scaled, saturated result
- vldout  out  1  result valid, one-cycle pulse
- saturation  out  1  qualified with vldout; high if the result was clipped

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low. All flops clear on reset: delay line, coefficients, CTRL, SCALE, counters, pipeline, result, vldout, saturation.
- APB write: occurs on psel&penable&pwrite. prdata = register value when psel&!pwrite, else 0. Unmapped reads return 0; unmapped writes are ignored.
- Register map:
  - 0x00 CTRL RW: bit0 enable, bit1 round, bits[7:4] DEC (decimation factor = DEC+1).
  - 0x04 SCALE RW: [SHW-1:0].
  - 0x08 GOODS RO.
  - 0x0C BADS RO.
  - 0x10 CLR WO: writing bit0=1 zeroes both counters; reads return 0.
  - 0x20+4*i COEF[i] RW: [CW-1:0], i < TAPS; read back sign-extended to 32 bits.
- Delay line: x[0..TAPS-1]. On vldin, x[0] <= sample and x[i] <= x[i-1]. Shifting happens regardless of enable.
- Stage 1 (cycle after vldin): register the products p[i] = x'[i]*COEF[i], where x' is the post-shift line. Products are full precision, DW+CW bits.
- Stage 2:
  - acc = sum of p[i], width DW+CW+clog2(TAPS); no internal overflow is possible.
  - If round=1 and SCALE>0: acc += 1<<(SCALE-1).
  - Arithmetic shift right by SCALE.
  - If the shifted value > 2^(DW-1)-1: result = max and saturation = 1. If it is < -2^(DW-1): result = min and saturation = 1. Otherwise result = the value and saturation = 0.
- Latency: vldin at cycle T produces vldout at T+2 (when emitted). Back-to-back vldin gives back-to-back results.
- Decimation:
  - A phase counter advances on each vldin while enable=1 and wraps at DEC.
  - A result is emitted (vldout=1) only when enable=1 and phase==0 at vldin.
  - Phase is reset to 0 when enable=0 and on any CTRL write.
- Output holding: result and saturation hold their last value when vldout=0. vldout=0 whenever enable=0.
- Counters:
  - On each vldout, GOODS increments if saturation=0 and BADS increments if saturation=1.
  - Both counters stick at 2^CNTW-1 (no wrap).
  - Both are held at 0 while enable=0.
  - A CLR write in the same cycle as an increment: clear wins.
- Coefficient writes mid-stream: a new coefficient is used by any stage-1 computation in cycles after the write cycle. A sample already in stage 2 is unaffected.
- Enable deassertion mid-pipeline: in-flight results are suppressed (vldout stays 0).
- Reset mid-operation: pipeline flushes immediately; no vldout is produced after reset deasserts until new samples arrive.

Test Plan:
- TAPS=4, COEF={1,0,0,0}, SCALE=0, enable=1, DEC=0; samples 5,-3,127 on consecutive cycles -> result 5,-3,127 at T+2,T+3,T+4; saturation=0; GOODS=3.
- COEF={64,64,64,64}, SCALE=2, four samples of 100 -> fourth result is acc 25600>>2 = 6400, so clipped to 127 with saturation=1; BADS increments.
- Same setup with samples of -100 -> result -128 with saturation=1. Separately, round=1, SCALE=1, acc=3 -> result 2; round=0 -> result 1.
- DEC=2 (factor 3), 9 valid samples -> exactly 3 vldout pulses, on samples 1, 4 and 7; CTRL rewrite mid-stream restarts phase.
- Force GOODS near max (CNTW=4 build), 20 good results -> GOODS=15; CLR write coincident with vldout -> both counters read 0.
- Reset asserted one cycle after vldin -> no vldout, all registers read 0; enable=0 -> counters 0 and vldout never asserts.

Source files
------------

// File: rtl/fir_engine.sv
// Purpose: APB-configured signed FIR filter with scaling, rounding, saturation, decimation and result counters.
// Latency: vldin at cycle T gives vldout at cycle T+2 (products registered, then scaled result registered).
// Backpressure: none; every vldin is accepted and results cannot be stalled (pready is tied high).
module fir_engine #(
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int TAPS = 8,
  parameter int SHW  = 4,
  parameter int CNTW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 psel,
  input  logic [7:0]           paddr,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [31:0]          pwdata,
  output logic                 pready,
  output logic [31:0]          prdata,
  input  logic signed [DW-1:0] sample,
  input  logic                 vldin,
  output logic signed [DW-1:0] result,
  output logic                 vldout,
  output logic                 saturation
);

  localparam int PW = DW + CW;                 // full-precision product
  localparam int AW = DW + CW + $clog2(TAPS);  // accumulator, cannot overflow
  localparam int SW = AW + 1;                  // headroom for the rounding add

  // Configuration and state registers
  logic signed [DW-1:0] r_x    [TAPS];
  logic signed [CW-1:0] r_coef [TAPS];
  logic signed [PW-1:0] r_prod [TAPS];
  logic                 r_en;
  logic                 r_rnd;
  logic [3:0]           r_dec;
  logic [3:0]           r_phase;
  logic [SHW-1:0]       r_scale;
  logic [CNTW-1:0]      r_goods;
  logic [CNTW-1:0]      r_bads;
  logic                 r_s1_vld;
  logic signed [DW-1:0] r_result;
  logic                 r_vldout;
  logic                 r_sat;

  // APB decode
  logic [5:0]  w_word;
  logic        w_wr;
  logic        w_ctrl_wr;
  logic        w_scale_wr;
  logic        w_clr;
  logic [31:0] w_rdata;
  logic        w_unused_bits;

  assign w_word        = paddr[7:2];
  assign w_wr          = psel & penable & pwrite;
  assign w_ctrl_wr     = w_wr && (w_word == 6'd0);
  assign w_scale_wr    = w_wr && (w_word == 6'd1);
  assign w_clr         = w_wr && (w_word == 6'd4) && pwdata[0];
  assign w_unused_bits = &{1'b0, paddr[1:0], pwdata};
  assign pready        = 1'b1;
  assign prdata        = (psel && !pwrite) ? w_rdata : 32'd0;

  // Read mux: unmapped words and CLR read as zero, coefficients sign-extended
  always_comb begin
    w_rdata = 32'd0;
    case (w_word)
      6'd0:    w_rdata = {24'd0, r_dec, 2'b00, r_rnd, r_en};
      6'd1:    w_rdata = 32'(r_scale);
      6'd2:    w_rdata = 32'(r_goods);
      6'd3:    w_rdata = 32'(r_bads);
      default: w_rdata = 32'd0;
    endcase
    for (int i = 0; i < TAPS; i++) begin
      if (w_word == 6'(8 + i)) w_rdata = 32'(r_coef[i]);
    end
  end

  // Control, scale and coefficient registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en    <= 1'b0;
      r_rnd   <= 1'b0;
      r_dec   <= 4'd0;
      r_scale <= '0;
      for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_en  <= pwdata[0];
        r_rnd <= pwdata[1];
        r_dec <= pwdata[7:4];
      end
      if (w_scale_wr) r_scale <= pwdata[SHW-1:0];
      for (int i = 0; i < TAPS; i++) begin
        if (w_wr && (w_word == 6'(8 + i))) r_coef[i] <= pwdata[CW-1:0];
      end
    end
  end

  // Post-shift view of the delay line, used both to shift and to form products
  logic signed [DW-1:0] w_xn [TAPS];
  always_comb begin
    w_xn[0] = sample;
    for (int i = 1; i < TAPS; i++) w_xn[i] = r_x[i-1];
  end

  // Delay line shifts on every valid sample, independent of enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) r_x[i] <= '0;
    end else if (vldin) begin
      for (int i = 0; i < TAPS; i++) r_x[i] <= w_xn[i];
    end
  end

  // Decimation phase: restarts when disabled or whenever CTRL is written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= 4'd0;
    end else if (!r_en || w_ctrl_wr) begin
      r_phase <= 4'd0;
    end else if (vldin) begin
      r_phase <= (r_phase == r_dec) ? 4'd0 : r_phase + 4'd1;
    end
  end

  // Stage 1: register full-precision products with the coefficients current this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      for (int i = 0; i < TAPS; i++) r_prod[i] <= '0;
    end else begin
      r_s1_vld <= vldin && r_en && (r_phase == 4'd0);
      if (vldin) begin
        for (int i = 0; i < TAPS; i++) r_prod[i] <= PW'(w_xn[i]) * PW'(r_coef[i]);
      end
    end
  end

  // Stage 2 arithmetic: sum, optional round-half-up, arithmetic shift, clip
  logic signed [AW-1:0]    w_acc;
  logic signed [SW-1:0]    w_rnd_add;
  logic signed [SW-1:0]    w_sum;
  logic signed [SW-1:0]    w_shift;
  logic [SW-DW:0]          w_hi;
  logic                    w_ovf;
  logic signed [DW-1:0]    w_clip;

  // Adder tree and saturation logic feeding the result register
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < TAPS; i++) w_acc = w_acc + AW'(r_prod[i]);
    w_rnd_add = '0;
    if (r_rnd && (r_scale != '0)) w_rnd_add = SW'(1) << (r_scale - SHW'(1));
    w_sum   = SW'(w_acc) + w_rnd_add;
    w_shift = w_sum >>> r_scale;
    // Any disagreement among the bits above the result's sign bit means clipping
    w_hi    = w_shift[SW-1:DW-1];
    w_ovf   = !((&w_hi) || (~|w_hi));
    if (!w_ovf)
      w_clip = w_shift[DW-1:0];
    else if (w_shift[SW-1])
      w_clip = {1'b1, {(DW-1){1'b0}}};
    else
      w_clip = {1'b0, {(DW-1){1'b1}}};
  end

  // Stage 2 register: result and saturation hold between valid outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vldout <= 1'b0;
      r_result <= '0;
      r_sat    <= 1'b0;
    end else begin
      r_vldout <= r_s1_vld && r_en;
      if (r_s1_vld && r_en) begin
        r_result <= w_clip;
        r_sat    <= w_ovf;
      end
    end
  end

  assign result     = r_result;
  assign vldout     = r_vldout;
  assign saturation = r_sat;

  // Good/bad counters: sticky at max, cleared by CLR (which beats an increment) or disable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_goods <= '0;
      r_bads  <= '0;
    end else if (w_clr || !r_en) begin
      r_goods <= '0;
      r_bads  <= '0;
    end else if (r_vldout) begin
      if (!r_sat && !(&r_goods)) r_goods <= r_goods + CNTW'(1);
      if ( r_sat && !(&r_bads))  r_bads  <= r_bads  + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_fir_engine.sv
// Directed bench for fir_engine (TAPS=4, CNTW=4) with a queue-based output scoreboard.
// Stimulus pushes hand-computed results tagged with the cycle they must appear in.
// A negedge monitor pops and compares every vldout and flags late or unexpected outputs.
module tb_fir_engine;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              psel, penable, pwrite;
  logic [7:0]        paddr;
  logic [31:0]       pwdata;
  logic              pready;
  logic [31:0]       prdata;
  logic signed [7:0] sample;
  logic              vldin;
  logic signed [7:0] result;
  logic              vldout;
  logic              saturation;

  fir_engine #(.DW(8), .CW(8), .TAPS(4), .SHW(4), .CNTW(4)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .paddr(paddr), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata),
    .sample(sample), .vldin(vldin), .result(result), .vldout(vldout),
    .saturation(saturation)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [7:0] res;
    logic              sat;
    int                cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every vldout must match the head of the queue, in the expected cycle
  always @(negedge clk) begin
    if (vldout) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_vldout: got result=%0d sat=%0b at cycle %0d, expected no output",
                 result, saturation, cyc);
      end else begin
        e = q.pop_front();
        if (result !== e.res || saturation !== e.sat || cyc != e.cyc) begin
          n_err++;
          $display("FAIL output: got result=%0d sat=%0b cycle=%0d, expected result=%0d sat=%0b cycle=%0d",
                   result, saturation, cyc, e.res, e.sat, e.cyc);
        end
      end
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL missing_vldout: no output by cycle %0d, expected result=%0d sat=%0b at cycle %0d",
               cyc, q[0].res, q[0].sat, q[0].cyc);
      void'(q.pop_front());
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check(nm, prdata, exp);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Drive one sample this cycle; vldin stays high until stop() so calls chain back-to-back
  task automatic samp(input logic signed [7:0] s, input bit emit,
                      input logic signed [7:0] r, input logic st);
    @(posedge clk); #1;
    vldin = 1'b1; sample = s;
    if (emit) q.push_back('{res: r, sat: st, cyc: cyc + 2});
  endtask

  task automatic stop();
    @(posedge clk); #1;
    vldin = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'd0; pwdata = 32'd0; sample = 8'sd0; vldin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vldout", {31'd0, vldout}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_sat",    {31'd0, saturation}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    apb_rd(8'h00, 32'd0, "rst_ctrl");
    apb_rd(8'h04, 32'd0, "rst_scale");
    apb_rd(8'h08, 32'd0, "rst_goods");
    apb_rd(8'h20, 32'd0, "rst_coef0");

    // Register map: sign-extended coefficient readback, unmapped and CLR read as zero
    apb_wr(8'h24, 32'h0000_00FF);
    apb_rd(8'h24, 32'hFFFF_FFFF, "coef1_sext");
    apb_wr(8'h28, 32'h1234_5680);
    apb_rd(8'h28, 32'hFFFF_FF80, "coef2_trunc");
    apb_wr(8'h18, 32'hFFFF_FFFF);
    apb_rd(8'h18, 32'd0, "unmapped_rd");
    apb_rd(8'h10, 32'd0, "clr_rd");
    apb_rd(8'h30, 32'd0, "coef4_absent");
    apb_wr(8'h24, 32'd0);
    apb_wr(8'h28, 32'd0);

    // Identity filter: 5, -3, 127 back-to-back
    apb_wr(8'h20, 32'd1);
    apb_wr(8'h04, 32'd0);
    apb_wr(8'h00, 32'h1);
    samp(8'sd5,   1, 8'sd5,   1'b0);
    samp(-8'sd3,  1, -8'sd3,  1'b0);
    samp(8'sd127, 1, 8'sd127, 1'b0);
    stop();
    idle(4);
    @(negedge clk);
    check("hold_result", {24'd0, result}, 32'd127);
    check("hold_sat",    {31'd0, saturation}, 32'd0);
    apb_rd(8'h08, 32'd3, "goods_3");

    // Positive clipping: line holds 127,-3,5,0; all coef 64, SCALE 2
    for (int i = 0; i < 4; i++) apb_wr(8'(8'h20 + 4 * i), 32'd64);
    apb_wr(8'h04, 32'd2);
    repeat (4) samp(8'sd100, 1, 8'sd127, 1'b1);
    stop();
    idle(4);
    apb_rd(8'h0C, 32'd4, "bads_4");

    // Negative samples: sums 200, 0, -200, -400 (x64 >>2)
    samp(-8'sd100, 1, 8'sd127,   1'b1);
    samp(-8'sd100, 1, 8'sd0,     1'b0);
    samp(-8'sd100, 1, -8'sd128,  1'b1);
    samp(-8'sd100, 1, -8'sd128,  1'b1);
    stop();
    idle(4);
    apb_rd(8'h08, 32'd4, "goods_4");
    apb_rd(8'h0C, 32'd7, "bads_7");
    apb_wr(8'h10, 32'd1);
    apb_rd(8'h08, 32'd0, "goods_clr");
    apb_rd(8'h0C, 32'd0, "bads_clr");

    // Rounding: COEF={1,0,0,0}
    apb_wr(8'h20, 32'd1);
    for (int i = 1; i < 4; i++) apb_wr(8'(8'h20 + 4 * i), 32'd0);
    apb_wr(8'h04, 32'd1);
    apb_wr(8'h00, 32'h3);
    samp(8'sd3,  1, 8'sd2,  1'b0);
    samp(-8'sd3, 1, -8'sd1, 1'b0);
    samp(8'sd5,  1, 8'sd3,  1'b0);
    stop();
    apb_wr(8'h00, 32'h1);
    samp(8'sd3,  1, 8'sd1,  1'b0);
    samp(-8'sd3, 1, -8'sd2, 1'b0);
    samp(8'sd5,  1, 8'sd2,  1'b0);
    stop();
    apb_wr(8'h04, 32'd0);
    apb_wr(8'h00, 32'h3);
    samp(8'sd3,  1, 8'sd3,  1'b0);
    stop();
    idle(3);

    // Decimation by 3: samples 1,4,7 emitted; CTRL rewrite restarts the phase
    apb_wr(8'h00, 32'h21);
    for (int i = 0; i < 9; i++) samp(8'(10 + i), (i % 3) == 0, 8'(10 + i), 1'b0);
    stop();
    samp(8'sd20, 1, 8'sd20, 1'b0);
    samp(8'sd21, 0, 8'sd0,  1'b0);
    stop();
    apb_wr(8'h00, 32'h21);
    samp(8'sd22, 1, 8'sd22, 1'b0);
    samp(8'sd23, 0, 8'sd0,  1'b0);
    samp(8'sd24, 0, 8'sd0,  1'b0);
    samp(8'sd25, 1, 8'sd25, 1'b0);
    stop();
    idle(3);

    // Sticky counter: 20 good results into a 4-bit counter
    apb_wr(8'h00, 32'h1);
    apb_wr(8'h10, 32'd1);
    for (int i = 1; i <= 20; i++) samp(8'(i), 1, 8'(i), 1'b0);
    stop();
    idle(3);
    apb_rd(8'h08, 32'd15, "goods_sticky");
    apb_rd(8'h0C, 32'd0,  "bads_0");

    // CLR access lands in the same cycle as a vldout: clear must win
    fork
      begin samp(8'sd7, 1, 8'sd7, 1'b0); stop(); end
      begin @(posedge clk); apb_wr(8'h10, 32'd1); end
    join
    idle(2);
    apb_rd(8'h08, 32'd0, "goods_clr_wins");
    apb_rd(8'h0C, 32'd0, "bads_clr_wins");

    // Build up a count, then disable while a sample is in stage 1: no output appears
    samp(8'sd1, 1, 8'sd1, 1'b0);
    samp(8'sd2, 1, 8'sd2, 1'b0);
    stop();
    idle(3);
    apb_rd(8'h08, 32'd2, "goods_2");
    fork
      apb_wr(8'h00, 32'h0);
      begin @(posedge clk); samp(8'sd9, 0, 8'sd0, 1'b0); stop(); end
    join
    idle(4);
    apb_rd(8'h08, 32'd0, "goods_disabled");
    samp(8'sd4, 0, 8'sd0, 1'b0);
    samp(8'sd5, 0, 8'sd0, 1'b0);
    stop();
    idle(4);
    apb_rd(8'h0C, 32'd0, "bads_disabled");

    // Reset one cycle after vldin flushes the pipeline and all registers
    apb_wr(8'h00, 32'h1);
    samp(8'sd11, 0, 8'sd0, 1'b0);
    stop();
    rst_n = 1'b0;
    idle(2);
    #1;
    rst_n = 1'b1;
    idle(4);
    @(negedge clk);
    check("post_rst_result", {24'd0, result}, 32'd0);
    apb_rd(8'h00, 32'd0, "post_rst_ctrl");
    apb_rd(8'h04, 32'd0, "post_rst_scale");
    apb_rd(8'h20, 32'd0, "post_rst_coef0");
    apb_rd(8'h08, 32'd0, "post_rst_goods");
    apb_rd(8'h0C, 32'd0, "post_rst_bads");

    idle(3);
    check("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
